// File: rtl/calib_pulse_mon.sv
// Calibration pulse monitor: per-channel synchronised edge counting and pulse-width capture,
// plus a shared trigger strobe with a programmable dead-time after each trigger.
module calib_pulse_mon #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned CNT_W   = 12,
  parameter int unsigned WID_W   = 8,
  parameter int unsigned SAT     = 0,
  parameter int unsigned HOLDOFF = 4
) (
  input  logic                   CLK40,
  input  logic                   RST_RESYNC,
  input  logic [NCH-1:0]         PLS_IN,
  input  logic [NCH-1:0]         EN,
  input  logic                   CLR,
  output logic [NCH*CNT_W-1:0]   PLSCNT,
  output logic [NCH*WID_W-1:0]   PLSWID,
  output logic [NCH-1:0]         OVF,
  output logic                   TRG_PULSE
);

  localparam int unsigned HO_W = 8;

  typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;

  logic [NCH-1:0] s1, s2, s3;
  logic [NCH-1:0] rise, fall;
  state_t         state;
  logic [HO_W-1:0] hcnt;

  // Two-flop synchroniser plus history flop for edge detection
  always_ff @(posedge CLK40 or posedge RST_RESYNC) begin
    if (RST_RESYNC) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= PLS_IN;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [WID_W-1:0] run;
    logic [WID_W-1:0] wid;
    logic             ovf;

    // Counter, running width and width capture; CLR outranks any same-cycle edge
    always_ff @(posedge CLK40 or posedge RST_RESYNC) begin
      if (RST_RESYNC) begin
        cnt <= '0;
        run <= '0;
        wid <= '0;
        ovf <= 1'b0;
      end else if (CLR) begin
        cnt <= '0;
        run <= '0;
        wid <= '0;
        ovf <= 1'b0;
      end else begin
        if (rise[i] && EN[i]) begin
          if (&cnt) begin
            ovf <= 1'b1;
            if (SAT == 0) cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        if (rise[i]) begin
          run <= WID_W'(1);
        end else if (s2[i] && !(&run)) begin
          run <= run + WID_W'(1);
        end
        if (fall[i]) wid <= run;
      end
    end

    assign PLSCNT[i*CNT_W +: CNT_W] = cnt;
    assign PLSWID[i*WID_W +: WID_W] = wid;
    assign OVF[i]                   = ovf;
  end

  // Trigger FSM; the strobe is a registered decode of FIRE, one edge after entering it
  always_ff @(posedge CLK40 or posedge RST_RESYNC) begin
    if (RST_RESYNC) begin
      state     <= IDLE;
      hcnt      <= '0;
      TRG_PULSE <= 1'b0;
    end else begin
      TRG_PULSE <= (state == FIRE);
      case (state)
        IDLE: begin
          if (|(rise & EN)) state <= FIRE;
        end
        FIRE: begin
          if (HOLDOFF <= 1) begin
            state <= IDLE;
          end else begin
            state <= HOLD;
            hcnt  <= HO_W'(HOLDOFF - 1);
          end
        end
        HOLD: begin
          if (hcnt == '0) state <= IDLE;
          else            hcnt  <= hcnt - HO_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/calib_pulse_mon.md
CALIB_PULSE_MON -- requirements
Module: calib_pulse_mon

Interface
REQ-001 Parameter NCH, default 2, number of calibration pulse channels (1..8).
REQ-002 Parameter CNT_W, default 12, width of each per-channel pulse counter (4..32).
REQ-003 Parameter WID_W, default 8, width of each per-channel pulse-width capture (2..16).
REQ-004 Parameter SAT, default 0; 0 = counters wrap, 1 = counters saturate at all-ones.
REQ-005 Parameter HOLDOFF, default 4, trigger dead-time in CLK40 cycles after a trigger (1..255).
REQ-006 CLK40  input  1  sole clock, all state on rising edge.
REQ-007 RST_RESYNC  input  1  reset, asynchronous, active-high.
REQ-008 PLS_IN  input  NCH  raw calibration pulse levels, asynchronous to CLK40.
REQ-009 EN  input  NCH  per-channel enable for counting and trigger contribution.
REQ-010 CLR  input  1  synchronous clear of counters, widths and overflow flags.
REQ-011 PLSCNT  output  NCH*CNT_W  packed counters, channel i in bits [i*CNT_W +: CNT_W].
REQ-012 PLSWID  output  NCH*WID_W  packed last-completed pulse widths, channel i in [i*WID_W +: WID_W].
REQ-013 OVF  output  NCH  sticky per-channel counter overflow flag.
REQ-014 TRG_PULSE  output  1  registered one-cycle trigger strobe.

Function
REQ-015 Each PLS_IN bit passes through a 2-flop synchroniser (s1,s2) plus a history flop s3; all three reset to 0.
REQ-016 Rise on channel i: s2 & ~s3; fall: ~s2 & s3; evaluated every cycle.
REQ-017 On a rise with EN[i]=1 and CLR=0, counter i increments on the next edge; PLS_IN high first sampled at edge k -> PLSCNT updated at edge k+2.
REQ-018 SAT=0: counter all-ones + rise -> 0 and OVF[i] set.
REQ-019 SAT=1: counter all-ones + rise -> holds all-ones and OVF[i] set.
REQ-020 OVF[i] is sticky; cleared only by CLR or RST_RESYNC.
REQ-021 Per-channel running width counter: loads 1 on a rise, increments while s2=1, saturates at 2^WID_W-1; independent of EN.
REQ-022 On a fall, running width (cycles s2 was high) is captured into PLSWID[i] on the next edge; PLSWID holds until the next fall.
REQ-023 CLR=1 zeros all PLSCNT, PLSWID, OVF and running widths on the next edge; CLR wins over a simultaneous rise (count = 0, not 1).
REQ-024 CLR does not affect synchronisers or the trigger state machine.
REQ-025 Trigger FSM states IDLE, FIRE, HOLD; reset state IDLE.
REQ-026 IDLE -> FIRE when any channel has rise & EN; otherwise stay.
REQ-027 FIRE: TRG_PULSE=1 for exactly one cycle; -> HOLD with holdoff counter = HOLDOFF-1 (HOLDOFF=1 -> IDLE directly).
REQ-028 HOLD: decrement each cycle, rises ignored for triggering (still counted); -> IDLE when counter reaches 0.
REQ-029 Simultaneous rises on several channels produce one trigger; each channel's counter still increments.
REQ-030 TRG_PULSE is a flop output (Moore decode of FIRE); first asserted at edge k+3 for a pulse first sampled at edge k.
REQ-031 EN change takes effect on the same-cycle rise evaluation; a rise with EN[i]=0 is lost, not deferred.

Reset
REQ-032 RST_RESYNC asserted: PLSCNT=0, PLSWID=0, OVF=0, TRG_PULSE=0, FSM=IDLE, synchronisers and running widths 0, immediately without a clock.
REQ-033 Deassertion with PLS_IN already high is treated as a new rise (counted, triggers if enabled).
REQ-034 Reset mid-pulse discards the in-progress width; no PLSWID capture for that pulse.

Verification
REQ-035 NCH=2, EN=11, 3-cycle pulse on ch0 -> PLSCNT ch0 = 1 at k+2, PLSWID ch0 = 3 after fall, TRG_PULSE one cycle at k+3, ch1 = 0.
REQ-036 CNT_W=4, SAT=0, 16 pulses on ch0 -> count wraps to 0, OVF[0]=1; repeat with SAT=1 -> count stays 15, OVF[0]=1.
REQ-037 HOLDOFF=4, pulses on ch0 every 2 cycles -> TRG_PULSE at most once per 5 cycles (FIRE + 4 HOLD) while counter counts every pulse.
REQ-038 CLR asserted in the same cycle as a rise at count 7 -> count 0, OVF 0, PLSWID 0 next cycle.
REQ-039 EN[1]=0, pulse on ch1 -> PLSCNT ch1 unchanged, no TRG_PULSE, PLSWID ch1 still updated.
REQ-040 RST_RESYNC asserted mid-pulse (count 5) then released with PLS_IN high -> outputs 0 asynchronously; count 1 three edges after release.
